// File: rtl/rr_bank_scheduler_pkg.sv
// Shared constants and width helpers for the round-robin bank scheduler.
// Word layout everywhere is {valid, we, addr, value} with value in the LSBs.
package rr_sched_pkg;

  localparam int RR_MODE    = 0;
  localparam int FIXED_MODE = 1;
  localparam int VALUE_LSB  = 0;

  function automatic int bank_bits(input int nbanks);
    return $clog2(nbanks);
  endfunction

  function automatic int local_addr_width(input int aw, input int nbanks);
    return aw - $clog2(nbanks);
  endfunction

  function automatic int req_width(input int aw, input int vw);
    return aw + vw + 2;
  endfunction

  function automatic int out_width(input int aw, input int vw, input int nbanks);
    return local_addr_width(aw, nbanks) + vw + 2;
  endfunction

  // Field positions for a word whose address field is aw bits wide.
  function automatic int valid_bit(input int aw, input int vw);
    return aw + vw + 1;
  endfunction

  function automatic int we_bit(input int aw, input int vw);
    return aw + vw;
  endfunction

  function automatic int addr_lsb(input int vw);
    return vw;
  endfunction

  function automatic int idx_width(input int g);
    return (g > 1) ? $clog2(g) : 1;
  endfunction

endpackage

// File: rtl/rr_bank_scheduler_if.sv
// Consumer-side request/grant bus and kernel-side output bus of the scheduler.
// master = consumers and banks, slave = the scheduler itself.
interface rr_bank_scheduler_if #(
  parameter int ADDR_WIDTH  = 4,
  parameter int VALUE_WIDTH = 8,
  parameter int NCONSUMERS  = 8,
  parameter int NBANKS      = 4,
  parameter int NPORTS      = 2
);
  import rr_sched_pkg::*;

  localparam int REQ_WIDTH = req_width(ADDR_WIDTH, VALUE_WIDTH);
  localparam int OUT_WIDTH = out_width(ADDR_WIDTH, VALUE_WIDTH, NBANKS);
  localparam int NKERNELS  = NBANKS * NPORTS;

  logic [NCONSUMERS-1:0][REQ_WIDTH-1:0] requests;
  logic [NCONSUMERS-1:0]                grant;
  logic [NKERNELS-1:0]                  bank_ready;
  logic [NKERNELS-1:0][OUT_WIDTH-1:0]   out;

  modport master (output requests, output bank_ready, input grant, input out);
  modport slave  (input requests, input bank_ready, output grant, output out);

endinterface

// File: rtl/rr_bank_scheduler_arbiter.sv
// Single-kernel arbiter: picks one eligible local index, round-robin after pivot
// or lowest-index-first; purely combinational, no grant when enable is low.
module rr_arbiter
  import rr_sched_pkg::*;
#(
  parameter  int G    = 4,
  parameter  int MODE = RR_MODE,
  localparam int IW   = idx_width(G)
) (
  input  logic [G-1:0]  eligible,
  input  logic [IW-1:0] pivot,
  input  logic          enable,
  output logic [G-1:0]  grant,
  output logic [IW-1:0] index
);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < G; i++) begin
      if (MODE == FIXED_MODE) begin
        cand = IW'(i);
      end else begin
        cand = IW'((int'(pivot) + 1 + i) % G);
      end
      if (enable && !found && eligible[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        index       = cand;
      end
    end
  end

endmodule

// File: rtl/rr_bank_scheduler.sv
// Routes NCONSUMERS requests onto NBANKS x NPORTS kernels, one grant per kernel per cycle.
// Output registered one cycle after grant; a kernel stalls (holds out, grants nothing) while its valid out sees bank_ready low.
module rr_bank_scheduler
  import rr_sched_pkg::*;
#(
  parameter int ADDR_WIDTH  = 4,
  parameter int VALUE_WIDTH = 8,
  parameter int NCONSUMERS  = 8,
  parameter int NBANKS      = 4,
  parameter int NPORTS      = 2,
  parameter int MODE        = RR_MODE
) (
  input logic                clk,
  input logic                reset,
  rr_bank_scheduler_if.slave bus
);

  localparam int BANK_BITS        = bank_bits(NBANKS);
  localparam int LOCAL_ADDR_WIDTH = local_addr_width(ADDR_WIDTH, NBANKS);
  localparam int OUT_WIDTH        = out_width(ADDR_WIDTH, VALUE_WIDTH, NBANKS);
  localparam int NKERNELS         = NBANKS * NPORTS;
  localparam int G                = NCONSUMERS / NPORTS;
  localparam int IW               = idx_width(G);
  localparam int CW               = $clog2(NCONSUMERS);

  localparam int RV = valid_bit(ADDR_WIDTH, VALUE_WIDTH);
  localparam int RW = we_bit(ADDR_WIDTH, VALUE_WIDTH);
  localparam int RA = addr_lsb(VALUE_WIDTH);
  localparam int OV = valid_bit(LOCAL_ADDR_WIDTH, VALUE_WIDTH);

  logic [NKERNELS-1:0][OUT_WIDTH-1:0] out_q;
  logic [NKERNELS-1:0][OUT_WIDTH-1:0] next_dat;
  logic [NKERNELS-1:0][IW-1:0]        pivot_q;
  logic [NKERNELS-1:0][IW-1:0]        kidx;
  logic [NKERNELS-1:0][G-1:0]         kgnt;
  logic [NKERNELS-1:0]                slot_rdy;
  logic [NKERNELS-1:0]                kany;
  logic [NCONSUMERS-1:0]              grant_vld;

  for (genvar k = 0; k < NKERNELS; k++) begin : g_kern
    localparam int                   P = k % NPORTS;
    localparam logic [BANK_BITS-1:0] B = BANK_BITS'(k / NPORTS);

    logic [G-1:0]    elig;
    logic [CW-1:0]   sel_c;

    // Local index l on this port is consumer l*NPORTS+P.
    always_comb begin
      elig = '0;
      for (int l = 0; l < G; l++) begin
        elig[l] = bus.requests[l*NPORTS+P][RV] &&
                  (bus.requests[l*NPORTS+P][RA +: BANK_BITS] == B);
      end
    end

    assign slot_rdy[k] = !out_q[k][OV] || bus.bank_ready[k];

    rr_arbiter #(
      .G    (G),
      .MODE (MODE)
    ) u_arb (
      .eligible (elig),
      .pivot    (pivot_q[k]),
      .enable   (slot_rdy[k] && reset),
      .grant    (kgnt[k]),
      .index    (kidx[k])
    );

    assign kany[k]     = |kgnt[k];
    assign sel_c       = CW'(int'(kidx[k]) * NPORTS + P);
    assign next_dat[k] = {1'b1,
                          bus.requests[sel_c][RW],
                          bus.requests[sel_c][RA+ADDR_WIDTH-1 : RA+BANK_BITS],
                          bus.requests[sel_c][VALUE_LSB +: VALUE_WIDTH]};
  end

  always_comb begin
    grant_vld = '0;
    for (int k = 0; k < NKERNELS; k++) begin
      for (int l = 0; l < G; l++) begin
        if (kgnt[k][l]) begin
          grant_vld[l*NPORTS + k%NPORTS] = 1'b1;
        end
      end
    end
  end

  assign bus.grant = reset ? grant_vld : '0;
  assign bus.out   = out_q;

  // Pivot resets to G-1 so the first round-robin scan starts at local index 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_q <= '0;
      for (int k = 0; k < NKERNELS; k++) begin
        pivot_q[k] <= IW'(G - 1);
      end
    end else begin
      for (int k = 0; k < NKERNELS; k++) begin
        if (kany[k]) begin
          out_q[k] <= next_dat[k];
          if (MODE == RR_MODE) begin
            pivot_q[k] <= kidx[k];
          end
        end else if (bus.bank_ready[k]) begin
          out_q[k] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rr_bank_scheduler.sv
// Randomized bench for rr_bank_scheduler: one round-robin and one fixed-priority instance,
// each checked every cycle against a queue-free behavioural model of the scheduling rules.
module tb_rr_bank_scheduler;
  import rr_sched_pkg::*;

  localparam int AW   = 4;
  localparam int VW   = 8;
  localparam int NC   = 8;
  localparam int NB   = 4;
  localparam int NP   = 2;
  localparam int G    = NC / NP;
  localparam int NK   = NB * NP;
  localparam int LAW  = AW - 2;
  localparam int REQW = AW + VW + 2;
  localparam int OUTW = LAW + VW + 2;
  localparam int NCYC = 2500;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  rr_bank_scheduler_if #(.ADDR_WIDTH(AW), .VALUE_WIDTH(VW), .NCONSUMERS(NC),
                         .NBANKS(NB), .NPORTS(NP)) bus0 ();
  rr_bank_scheduler_if #(.ADDR_WIDTH(AW), .VALUE_WIDTH(VW), .NCONSUMERS(NC),
                         .NBANKS(NB), .NPORTS(NP)) bus1 ();

  rr_bank_scheduler #(.ADDR_WIDTH(AW), .VALUE_WIDTH(VW), .NCONSUMERS(NC),
                      .NBANKS(NB), .NPORTS(NP), .MODE(RR_MODE))
    dut0 (.clk(clk), .reset(reset), .bus(bus0));
  rr_bank_scheduler #(.ADDR_WIDTH(AW), .VALUE_WIDTH(VW), .NCONSUMERS(NC),
                      .NBANKS(NB), .NPORTS(NP), .MODE(FIXED_MODE))
    dut1 (.clk(clk), .reset(reset), .bus(bus1));

  int total = 0;
  int bad   = 0;

  // Consumer request state, per instance (0 = round-robin, 1 = fixed priority).
  int r_vld[2][NC], r_we[2][NC], r_addr[2][NC], r_val[2][NC];
  int br[2][NK];
  // Model of each kernel's output slot and pivot.
  int m_vld[2][NK], m_we[2][NK], m_la[2][NK], m_val[2][NK], m_piv[2][NK];
  int gsel[2][NK];
  int exp_g[2][NC];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [REQW-1:0] req_word(input int m, input int c);
    return {r_vld[m][c][0], r_we[m][c][0], r_addr[m][c][AW-1:0], r_val[m][c][VW-1:0]};
  endfunction

  task automatic drive();
    for (int c = 0; c < NC; c++) begin
      bus0.requests[c] = req_word(0, c);
      bus1.requests[c] = req_word(1, c);
    end
    for (int k = 0; k < NK; k++) begin
      bus0.bank_ready[k] = br[0][k][0];
      bus1.bank_ready[k] = br[1][k][0];
    end
  endtask

  // Who should each kernel grant right now, given the current requests and slot state.
  task automatic predict(input int m);
    for (int c = 0; c < NC; c++) exp_g[m][c] = 0;
    for (int k = 0; k < NK; k++) begin
      gsel[m][k] = -1;
      if (reset && (m_vld[m][k] == 0 || br[m][k] != 0)) begin
        for (int i = 0; i < G; i++) begin
          int l;
          int c;
          l = (m == 1) ? i : (m_piv[m][k] + 1 + i) % G;
          c = l * NP + k % NP;
          if (gsel[m][k] < 0 && r_vld[m][c] != 0 && (r_addr[m][c] % NB) == k / NP) begin
            gsel[m][k]  = c;
            exp_g[m][c] = 1;
          end
        end
      end
    end
  endtask

  task automatic edge_update(input int m);
    for (int k = 0; k < NK; k++) begin
      if (!reset) begin
        m_vld[m][k] = 0; m_we[m][k] = 0; m_la[m][k] = 0; m_val[m][k] = 0;
        m_piv[m][k] = G - 1;
      end else if (gsel[m][k] >= 0) begin
        m_vld[m][k] = 1;
        m_we[m][k]  = r_we[m][gsel[m][k]];
        m_la[m][k]  = r_addr[m][gsel[m][k]] / NB;
        m_val[m][k] = r_val[m][gsel[m][k]];
        if (m == 0) m_piv[m][k] = gsel[m][k] / NP;
      end else if (br[m][k] != 0) begin
        m_vld[m][k] = 0; m_we[m][k] = 0; m_la[m][k] = 0; m_val[m][k] = 0;
      end
    end
  endtask

  // Phases: hot-spot on kernel 2 (with a stall and a reset), idle, then random traffic.
  task automatic stimulus(input int m, input int cyc);
    for (int c = 0; c < NC; c++) begin
      if (r_vld[m][c] != 0 && exp_g[m][c] == 0) continue;
      r_we[m][c]  = $urandom_range(0, 1);
      r_addr[m][c] = $urandom_range(0, 15);
      r_val[m][c] = $urandom_range(0, 255);
      if (cyc < 60) begin
        if (c == 0 || c == 2 || c == 4) begin
          r_vld[m][c]  = 1;
          r_addr[m][c] = 5;
          r_val[m][c]  = 16 * (c / 2 + 1);
          r_we[m][c]   = (c == 2) ? 1 : 0;
        end else begin
          r_vld[m][c] = 0;
        end
      end else if (cyc < 80) begin
        r_vld[m][c] = 0;
      end else begin
        r_vld[m][c] = ($urandom_range(0, 9) < 6) ? 1 : 0;
        if ($urandom_range(0, 3) == 0)
          r_addr[m][c] = $urandom_range(0, 3) * NB + $urandom_range(0, 3);
        else
          r_addr[m][c] = $urandom_range(0, 3) * NB + $urandom_range(0, 1);
      end
    end
    for (int k = 0; k < NK; k++) begin
      if (cyc < 80)
        br[m][k] = (k == 2 && cyc >= 40 && cyc < 43) ? 0 : 1;
      else
        br[m][k] = ($urandom_range(0, 3) != 0) ? 1 : 0;
    end
  endtask

  task automatic compare(input int m);
    logic [NC-1:0]            eg;
    logic [NC-1:0]            gg;
    logic [NK-1:0][OUTW-1:0]  go;
    logic [OUTW-1:0]          ew;
    for (int c = 0; c < NC; c++) eg[c] = exp_g[m][c][0];
    gg = (m == 0) ? bus0.grant : bus1.grant;
    go = (m == 0) ? bus0.out : bus1.out;
    check($sformatf("m%0d grant", m), 32'(gg), 32'(eg));
    for (int k = 0; k < NK; k++) begin
      if (m_vld[m][k] != 0) begin
        ew = {1'b1, m_we[m][k][0], m_la[m][k][LAW-1:0], m_val[m][k][VW-1:0]};
        check($sformatf("m%0d out%0d", m, k), 32'(go[k]), 32'(ew));
      end else begin
        check($sformatf("m%0d out%0d vld", m, k), 32'(go[k][OUTW-1]), 32'(0));
      end
    end
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < NC; c++) begin
        r_vld[m][c] = 0; r_we[m][c] = 0; r_addr[m][c] = 0; r_val[m][c] = 0; exp_g[m][c] = 0;
      end
      for (int k = 0; k < NK; k++) begin
        br[m][k] = 1; gsel[m][k] = -1; m_piv[m][k] = G - 1;
        m_vld[m][k] = 0; m_we[m][k] = 0; m_la[m][k] = 0; m_val[m][k] = 0;
      end
    end
    drive();
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      edge_update(0);
      edge_update(1);
      #1;
      reset = !(cyc < 3 || cyc == 25 || (cyc >= 100 && $urandom_range(0, 99) == 0));
      stimulus(0, cyc);
      stimulus(1, cyc);
      drive();
      @(negedge clk);
      predict(0);
      predict(1);
      compare(0);
      compare(1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
